// File: rtl/picomips_io_pkg.sv
// Shared types and defaults for the picoMIPS switch front end.
// The debounce FSM state encoding lives here so checkers and the RTL agree on it.
package picomips_io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } sw_state_t;

  localparam int DEFAULT_DB_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
// Reset clears both stages so a held input reappears only after the full 2-cycle latency.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch/SW8 conditioner in front of picoMIPS: synchronises inputs, debounces SW8, latches data on press.
// Define SW_DEBOUNCE_EN for the full debounce FSM; leave it undefined for the fast 2-cycle simulation path.
module sw_input_conditioner
  import picomips_io_pkg::*;
#(
  parameter int n         = 8,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] sw_raw,
  input  logic         sw8_raw,
  output logic         sw8,
  output logic         sw8_rise,
  output logic [n-1:0] sw_data
);

  logic         s8;
  logic [n-1:0] sd;

  sync_2ff #(.W(n)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (sw_raw),
    .q     (sd)
  );

  sync_2ff #(.W(1)) u_sync_sw8 (
    .clk   (clk),
    .reset (reset),
    .d     (sw8_raw),
    .q     (s8)
  );

`ifdef SW_DEBOUNCE_EN

  localparam int            CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  sw_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          accept;

  assign cnt_inc = cnt + CW'(1);

  // The IDLE/PRESSED sample that spots the new level counts as the first stable
  // cycle, so a DB_* state accepts when the incremented count hits DB_CYCLES-1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (s8) begin
          if (DB_CYCLES == 1) begin
            state_next = PRESSED;
            accept     = 1'b1;
          end else begin
            state_next = DB_PRESS;
          end
        end
      end
      DB_PRESS: begin
        if (!s8) begin
          state_next = IDLE;
        end else if (cnt_inc == LAST) begin
          state_next = PRESSED;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s8) begin
          state_next = (DB_CYCLES == 1) ? IDLE : DB_REL;
        end
      end
      DB_REL: begin
        if (s8) begin
          state_next = PRESSED;
        end else if (cnt_inc == LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sw8_rise <= 1'b0;
      sw_data  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sw8_rise <= accept;
      if (accept) sw_data <= sd;
    end
  end

  // DB_REL keeps sw8 high so a release bounce never reaches the core.
  assign sw8 = (state == PRESSED) || (state == DB_REL);

`else

  // Debounce length has no effect here; it only qualifies the build as sane.
  localparam bit DB_OK = (DB_CYCLES >= 1);

  logic sw8_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw8_prev <= 1'b0;
      sw_data  <= '0;
    end else begin
      sw8_prev <= s8;
      if (sw8_rise) sw_data <= sd;
    end
  end

  assign sw8      = s8;
  assign sw8_rise = DB_OK & s8 & ~sw8_prev;

`endif

endmodule
